alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one shared registered ALU (myalu, NUMBITS-wide, 3-bit opcode).
- Accepts operations over valid/ready request channels and drives the ALU operand and opcode inputs.
- Waits out the ALU's registered latency, then captures result and flags and returns them on the granted requester's response channel, with backpressure.
- Exactly one operation in flight at any time.

Parameters:
NUMBITS, 16, operand/result width; must match the ALU instance.
ALU_LATENCY, 1, clock edges from ALU inputs stable to ALU outputs valid; legal range 1..15.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester request accept
req_a0, req_b0  in  NUMBITS each  requester 0 operands
req_op0  in  3  requester 0 opcode
req_a1, req_b1  in  NUMBITS each  requester 1 operands
req_op1  in  3  requester 1 opcode
resp_valid  out  2  per-requester response valid
resp_ready  in  2  per-requester response accept
resp_result  out  NUMBITS  captured ALU result, shared by both requesters
resp_carry, resp_overflow, resp_zero  out  1 each  captured ALU flags
alu_a, alu_b  out  NUMBITS each  to ALU A/B
alu_opcode  out  3  to ALU opcode
alu_result  in  NUMBITS  from ALU result
alu_carryout, alu_overflow, alu_zero  in  1 each  from ALU flags
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values:
  - State IDLE, rr_last = 1, so requester 0 wins the first contention.
  - alu_a, alu_b, alu_opcode, resp_result and all flags = 0.
  - resp_valid = 2'b00, busy = 0.
  - req_ready forced to 2'b00 while reset is high.
- States: IDLE -> EXEC -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - grant = requester i if only req_valid[i] is high.
  - If both are high, grant = the requester other than rr_last.
  - req_ready[grant] is combinationally high and the other bit low; req_ready = 0 when no requester is valid.
  - Handshake happens when req_valid[grant] and req_ready[grant] are both high. On that edge:
    - latch the granted operands and opcode into the alu_a/alu_b/alu_opcode registers;
    - store the owner index;
    - set rr_last = grant;
    - load lat_cnt = ALU_LATENCY;
    - go to EXEC.
- EXEC:
  - alu_* held stable; lat_cnt decrements each cycle.
  - Go to CAPTURE on the edge where lat_cnt == 1, so EXEC lasts exactly ALU_LATENCY cycles.
- CAPTURE (1 cycle): register alu_result and the three flags into resp_*, then go to RESP.
- RESP:
  - resp_valid[owner] = 1 and the other bit 0; resp_* held stable.
  - On resp_valid[owner] & resp_ready[owner], go to IDLE with resp_valid cleared on that edge.
  - Stall indefinitely while resp_ready[owner] is low.
- Latency: handshake edge at cycle T; resp_valid is first high in cycle T+ALU_LATENCY+2. Minimum issue interval is ALU_LATENCY+3 cycles.
- req_ready is 0 in every state but IDLE. Requests arriving while busy wait; they are not dropped.
- resp_ready on the non-owner bit is ignored.
- alu_* hold their last value in IDLE. They change only on an accepted handshake.
- Reset mid-operation (any state): return to the reset values. The in-flight op is discarded and no response is produced. The ALU shares reset and clears itself.
- No opcode checking: all 8 opcodes pass through unchanged. Result width is NUMBITS and flags are taken verbatim from the ALU.
- Fairness: with both requesters continuously valid, grants strictly alternate.

Test Plan:
1. After reset, req0 only, A=0xFFFF, B=0x0001, op=0, resp_ready=1 -> req_ready=2'b01 in the accept cycle; resp_valid[0] high exactly 3 cycles later (L=1) with result 0x0000, carry=1, zero=1, overflow=0; resp_valid[1] stays 0.
2. req1 only, A=0x7FFF, B=0x0001, op=1 -> resp_valid[1] with result 0x8000, overflow=1, carry=0, zero=0.
3. Both valid on the first cycle after reset (req0 op=4 0x00F0&0x0F0F, req1 op=5 0x00F0|0x0F0F) -> req0 served first with result 0x0000, zero=1; then req1 with result 0x0FFF; 4 continuous ops complete in grant order 0,1,0,1.
4. Backpressure: resp_ready[0]=0 for 5 cycles during RESP -> resp_valid[0] and resp_result held stable; req_ready=2'b00 despite req1 valid; req1 accepted the cycle after resp_ready[0] handshakes.
5. Assert reset for 1 cycle during EXEC -> next cycle busy=0, resp_valid=0, all outputs 0; no response appears for the discarded op; a new req0 op=7 A=0x0009 returns 0x0004.
6. ALU_LATENCY=3 build, op=2, A=0x0003, B=0x0005 -> resp_valid 5 cycles after accept with result 0xFFFE, carry=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for two requesters sharing one registered ALU.
// One operation in flight; the result is held on the owner's response channel until accepted.
module alu_arbiter #(
    parameter int unsigned NUMBITS     = 16,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         i_req_valid,
    output logic [1:0]         o_req_ready,
    input  logic [NUMBITS-1:0] i_req_a0,
    input  logic [NUMBITS-1:0] i_req_b0,
    input  logic [2:0]         i_req_op0,
    input  logic [NUMBITS-1:0] i_req_a1,
    input  logic [NUMBITS-1:0] i_req_b1,
    input  logic [2:0]         i_req_op1,
    output logic [1:0]         o_resp_valid,
    input  logic [1:0]         i_resp_ready,
    output logic [NUMBITS-1:0] o_resp_result,
    output logic               o_resp_carry,
    output logic               o_resp_overflow,
    output logic               o_resp_zero,
    output logic [NUMBITS-1:0] o_alu_a,
    output logic [NUMBITS-1:0] o_alu_b,
    output logic [2:0]         o_alu_opcode,
    input  logic [NUMBITS-1:0] i_alu_result,
    input  logic               i_alu_carryout,
    input  logic               i_alu_overflow,
    input  logic               i_alu_zero,
    output logic               o_busy
);

    typedef enum logic [1:0] {StIdle, StExec, StCapture, StResp} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_rr_last;
    logic               r_owner;
    logic [3:0]         r_lat_cnt;
    logic [NUMBITS-1:0] r_alu_a;
    logic [NUMBITS-1:0] r_alu_b;
    logic [2:0]         r_alu_opcode;
    logic [NUMBITS-1:0] r_resp_result;
    logic               r_resp_carry;
    logic               r_resp_overflow;
    logic               r_resp_zero;

    logic               w_grant;
    logic               w_accept;
    logic               w_resp_fire;

    always_comb begin
        w_grant      = 1'b0;
        o_req_ready  = 2'b00;
        w_state_next = r_state;

        // On contention the requester that did not win last time goes next.
        if (i_req_valid == 2'b11) begin
            w_grant = ~r_rr_last;
        end else if (i_req_valid[1]) begin
            w_grant = 1'b1;
        end

        if (!reset && (r_state == StIdle) && (i_req_valid != 2'b00)) begin
            o_req_ready = w_grant ? 2'b10 : 2'b01;
        end

        w_accept    = (o_req_ready != 2'b00);
        w_resp_fire = (r_state == StResp) && i_resp_ready[r_owner];

        case (r_state)
            StIdle:    if (w_accept) w_state_next = StExec;
            StExec:    if (r_lat_cnt == 4'd1) w_state_next = StCapture;
            StCapture: w_state_next = StResp;
            StResp:    if (w_resp_fire) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= StIdle;
            r_rr_last       <= 1'b1;
            r_owner         <= 1'b0;
            r_lat_cnt       <= 4'd0;
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_alu_opcode    <= 3'd0;
            r_resp_result   <= '0;
            r_resp_carry    <= 1'b0;
            r_resp_overflow <= 1'b0;
            r_resp_zero     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_alu_a      <= w_grant ? i_req_a1 : i_req_a0;
                r_alu_b      <= w_grant ? i_req_b1 : i_req_b0;
                r_alu_opcode <= w_grant ? i_req_op1 : i_req_op0;
                r_owner      <= w_grant;
                r_rr_last    <= w_grant;
                r_lat_cnt    <= 4'(ALU_LATENCY);
            end
            if (r_state == StExec) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if (r_state == StCapture) begin
                r_resp_result   <= i_alu_result;
                r_resp_carry    <= i_alu_carryout;
                r_resp_overflow <= i_alu_overflow;
                r_resp_zero     <= i_alu_zero;
            end
        end
    end

    assign o_resp_valid    = (r_state == StResp) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign o_busy          = (r_state != StIdle);
    assign o_alu_a         = r_alu_a;
    assign o_alu_b         = r_alu_b;
    assign o_alu_opcode    = r_alu_opcode;
    assign o_resp_result   = r_resp_result;
    assign o_resp_carry    = r_resp_carry;
    assign o_resp_overflow = r_resp_overflow;
    assign o_resp_zero     = r_resp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a latency-1 and a latency-3 instance, each in front of a
// small behavioural ALU (0/1 add, 2/3 sub with borrow as carry, 4 and, 5 or, 6 xor, 7 shr).
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  t3_valid = 2'b00;
    logic [15:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [2:0]  req_op0 = '0, req_op1 = '0;
    logic [1:0]  resp_ready = 2'b11;

    logic [1:0]  req_ready, resp_valid;
    logic [15:0] resp_result, alu_a, alu_b, alu_result;
    logic        resp_carry, resp_overflow, resp_zero, busy;
    logic [2:0]  alu_opcode;
    logic        alu_carry, alu_ovf, alu_zero;

    logic [1:0]  d3_req_ready, d3_resp_valid;
    logic [15:0] d3_resp_result, d3_alu_a, d3_alu_b;
    logic        d3_resp_carry, d3_resp_overflow, d3_resp_zero, d3_busy;
    logic [2:0]  d3_alu_opcode;

    logic [18:0] alu1_q, p3_0, p3_1, p3_2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    function automatic logic [18:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd2, 3'd3: begin
                s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = a >> 1;
        endcase
        return {c, v, (r == 16'h0000), r};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            alu1_q <= '0; p3_0 <= '0; p3_1 <= '0; p3_2 <= '0;
        end else begin
            alu1_q <= alu_fn(alu_a, alu_b, alu_opcode);
            p3_0   <= alu_fn(d3_alu_a, d3_alu_b, d3_alu_opcode);
            p3_1   <= p3_0;
            p3_2   <= p3_1;
        end
    end

    assign {alu_carry, alu_ovf, alu_zero, alu_result} = alu1_q;

    alu_arbiter #(.NUMBITS(16), .ALU_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a0(req_a0), .i_req_b0(req_b0), .i_req_op0(req_op0),
        .i_req_a1(req_a1), .i_req_b1(req_b1), .i_req_op1(req_op1),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_result(resp_result),
        .o_resp_carry(resp_carry), .o_resp_overflow(resp_overflow), .o_resp_zero(resp_zero),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_opcode(alu_opcode),
        .i_alu_result(alu_result), .i_alu_carryout(alu_carry), .i_alu_overflow(alu_ovf),
        .i_alu_zero(alu_zero), .o_busy(busy)
    );

    alu_arbiter #(.NUMBITS(16), .ALU_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .i_req_valid(t3_valid), .o_req_ready(d3_req_ready),
        .i_req_a0(req_a0), .i_req_b0(req_b0), .i_req_op0(req_op0),
        .i_req_a1(req_a1), .i_req_b1(req_b1), .i_req_op1(req_op1),
        .o_resp_valid(d3_resp_valid), .i_resp_ready(2'b11), .o_resp_result(d3_resp_result),
        .o_resp_carry(d3_resp_carry), .o_resp_overflow(d3_resp_overflow),
        .o_resp_zero(d3_resp_zero), .o_alu_a(d3_alu_a), .o_alu_b(d3_alu_b),
        .o_alu_opcode(d3_alu_opcode), .i_alu_result(p3_2[15:0]), .i_alu_carryout(p3_2[18]),
        .i_alu_overflow(p3_2[17]), .i_alu_zero(p3_2[16]), .o_busy(d3_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle after the accept edge; n = cycles from accept to first resp_valid.
    task automatic wait_resp(output int n);
        n = 1;
        while (resp_valid === 2'b00 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b11;
        step();
        step();
        tests_run++;
        if (req_ready !== 2'b00) begin
            tests_failed++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        req_valid = 2'b00;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, resp_valid, alu_a, alu_b, alu_opcode} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b rv=%b a=%h b=%h op=%h want all 0",
                     busy, resp_valid, alu_a, alu_b, alu_opcode);
        end
        tests_run++;
        if ({resp_result, resp_carry, resp_overflow, resp_zero} !== '0) begin
            tests_failed++;
            $display("FAIL reset_resp: res=%h c=%b v=%b z=%b want 0", resp_result, resp_carry,
                     resp_overflow, resp_zero);
        end
    endtask

    task automatic test_req0_add();
        int n;
        req_valid = 2'b01; req_a0 = 16'hFFFF; req_b0 = 16'h0001; req_op0 = 3'd0;
        resp_ready = 2'b11;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++; $display("FAIL t1_req_ready: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        tests_run++;
        if (busy !== 1'b1 || alu_a !== 16'hFFFF || alu_b !== 16'h0001) begin
            tests_failed++;
            $display("FAIL t1_exec: busy=%b a=%h b=%h want 1 ffff 0001", busy, alu_a, alu_b);
        end
        wait_resp(n);
        tests_run++;
        if (n !== 3 || resp_valid !== 2'b01) begin
            tests_failed++; $display("FAIL t1_latency: n=%0d rv=%b want 3 01", n, resp_valid);
        end
        tests_run++;
        if ({resp_result, resp_carry, resp_overflow, resp_zero} !== {16'h0000, 3'b101}) begin
            tests_failed++;
            $display("FAIL t1_result: res=%h c=%b v=%b z=%b want 0000 1 0 1", resp_result,
                     resp_carry, resp_overflow, resp_zero);
        end
        step();
        tests_run++;
        if (resp_valid !== 2'b00 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL t1_done: rv=%b busy=%b want 00 0", resp_valid, busy);
        end
    endtask

    task automatic test_req1_add_ovf();
        int n;
        req_valid = 2'b10; req_a1 = 16'h7FFF; req_b1 = 16'h0001; req_op1 = 3'd1;
        #1;
        tests_run++;
        if (req_ready !== 2'b10) begin
            tests_failed++; $display("FAIL t2_req_ready: got %b want 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        wait_resp(n);
        tests_run++;
        if (n !== 3 || resp_valid !== 2'b10) begin
            tests_failed++; $display("FAIL t2_latency: n=%0d rv=%b want 3 10", n, resp_valid);
        end
        tests_run++;
        if ({resp_result, resp_carry, resp_overflow, resp_zero} !== {16'h8000, 3'b010}) begin
            tests_failed++;
            $display("FAIL t2_result: res=%h c=%b v=%b z=%b want 8000 0 1 0", resp_result,
                     resp_carry, resp_overflow, resp_zero);
        end
        step();
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0]  exp_g;
        logic [15:0] exp_r;
        reset = 1'b1;
        req_valid = 2'b11;
        req_a0 = 16'h00F0; req_b0 = 16'h0F0F; req_op0 = 3'd4;
        req_a1 = 16'h00F0; req_b1 = 16'h0F0F; req_op1 = 3'd5;
        step();
        tests_run++;
        if (req_ready !== 2'b00) begin
            tests_failed++; $display("FAIL t3_reset_ready: got %b want 00", req_ready);
        end
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (k % 2 == 0) ? 16'h0000 : 16'h0FFF;
            tests_run++;
            if (req_ready !== exp_g) begin
                tests_failed++;
                $display("FAIL t3_grant%0d: got %b want %b", k, req_ready, exp_g);
            end
            step();
            wait_resp(n);
            tests_run++;
            if (n !== 3 || resp_valid !== exp_g || resp_result !== exp_r ||
                resp_zero !== (k % 2 == 0)) begin
                tests_failed++;
                $display("FAIL t3_resp%0d: n=%0d rv=%b res=%h z=%b want 3 %b %h %b", k, n,
                         resp_valid, resp_result, resp_zero, exp_g, exp_r, (k % 2 == 0));
            end
            step();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        req_valid = 2'b01; req_a0 = 16'h1234; req_b0 = 16'h1111; req_op0 = 3'd0;
        req_a1 = 16'h00F0; req_b1 = 16'h0F0F; req_op1 = 3'd5;
        resp_ready = 2'b10;
        step();
        req_valid = 2'b10;
        wait_resp(n);
        tests_run++;
        if (n !== 3 || resp_valid !== 2'b01 || resp_result !== 16'h2345) begin
            tests_failed++;
            $display("FAIL t4_first: n=%0d rv=%b res=%h want 3 01 2345", n, resp_valid,
                     resp_result);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid !== 2'b01 || resp_result !== 16'h2345 || req_ready !== 2'b00) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL t4_stall: %0d bad cycles, rv=%b res=%h rdy=%b want 01 2345 00", bad,
                     resp_valid, resp_result, req_ready);
        end
        resp_ready = 2'b01;
        step();
        tests_run++;
        if (resp_valid !== 2'b00 || req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL t4_release: rv=%b rdy=%b want 00 10", resp_valid, req_ready);
        end
        resp_ready = 2'b11;
        step();
        req_valid = 2'b00;
        wait_resp(n);
        tests_run++;
        if (n !== 3 || resp_valid !== 2'b10 || resp_result !== 16'h0FFF) begin
            tests_failed++;
            $display("FAIL t4_second: n=%0d rv=%b res=%h want 3 10 0fff", n, resp_valid,
                     resp_result);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        int n;
        int bad;
        req_valid = 2'b01; req_a0 = 16'h0001; req_b0 = 16'h0001; req_op0 = 3'd0;
        step();
        req_valid = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if ({busy, resp_valid, alu_a, alu_b, alu_opcode, resp_result} !== '0) begin
            tests_failed++;
            $display("FAIL t5_cleared: busy=%b rv=%b a=%h b=%h op=%h res=%h want all 0", busy,
                     resp_valid, alu_a, alu_b, alu_opcode, resp_result);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid !== 2'b00 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL t5_no_resp: %0d cycles with activity, want 0", bad);
        end
        req_valid = 2'b01; req_a0 = 16'h0009; req_b0 = 16'h0000; req_op0 = 3'd7;
        step();
        req_valid = 2'b00;
        wait_resp(n);
        tests_run++;
        if (n !== 3 || resp_valid !== 2'b01 || resp_result !== 16'h0004) begin
            tests_failed++;
            $display("FAIL t5_new_op: n=%0d rv=%b res=%h want 3 01 0004", n, resp_valid,
                     resp_result);
        end
        step();
    endtask

    task automatic test_latency3();
        int n;
        t3_valid = 2'b01; req_a0 = 16'h0003; req_b0 = 16'h0005; req_op0 = 3'd2;
        #1;
        tests_run++;
        if (d3_req_ready !== 2'b01) begin
            tests_failed++; $display("FAIL t6_req_ready: got %b want 01", d3_req_ready);
        end
        step();
        t3_valid = 2'b00;
        n = 1;
        while (d3_resp_valid === 2'b00 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (n !== 5 || d3_resp_valid !== 2'b01) begin
            tests_failed++;
            $display("FAIL t6_latency: n=%0d rv=%b want 5 01", n, d3_resp_valid);
        end
        tests_run++;
        if (d3_resp_result !== 16'hFFFE || d3_resp_carry !== 1'b1) begin
            tests_failed++;
            $display("FAIL t6_result: res=%h c=%b want fffe 1", d3_resp_result, d3_resp_carry);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_req0_add();
        test_req1_add_ovf();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_latency3();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
